sync_w2r_level: RTL and testbench
=================================

SYNC_W2R_LEVEL -- requirements
Module: sync_w2r_level

Interface
REQ-001 The block SHALL have parameter ASIZE, default 4, meaning log2 of FIFO depth; pointers are ASIZE+1 bits wide.
REQ-002 The block SHALL have parameter STAGES, default 2, meaning the number of synchroniser flops; legal range 2..4.
REQ-003 The block SHALL have parameter AE_THRESH, default 2, meaning the almost-empty threshold in entries; legal range 0..2^ASIZE.
REQ-004 rclk  input  1  read-domain clock, rising edge.
REQ-005 rrstn_n  input  1  read-domain reset, asynchronous, active-low.
REQ-006 wptr  input  ASIZE+1  write pointer, Gray coded, write-domain register output.
REQ-007 rptr_bin  input  ASIZE+1  read pointer, binary, read-domain register output.
REQ-008 clr_err  input  1  synchronous clear of the sticky error flag.
REQ-009 rs_wptr  output  ASIZE+1  synchronised write pointer, Gray.
REQ-010 rs_wbin  output  ASIZE+1  synchronised write pointer, binary.
REQ-011 rlevel  output  ASIZE+1  read-domain fill level, entries.
REQ-012 rempty  output  1  FIFO empty, read domain.
REQ-013 ralmost_empty  output  1  rlevel <= AE_THRESH.
REQ-014 lvl_err  output  1  sticky: computed level exceeded 2^ASIZE.

Function
REQ-015 wptr SHALL pass through a chain of STAGES flops clocked by rclk; rs_wptr SHALL be the last stage; a wptr value stable for STAGES rclk edges SHALL appear on rs_wptr after exactly STAGES edges.
REQ-016 No logic SHALL sit between wptr and the first synchroniser flop, nor between synchroniser stages.
REQ-017 rs_wbin SHALL be the combinational Gray-to-binary conversion of rs_wptr: bit i = XOR of rs_wptr bits ASIZE..i.
REQ-018 The raw level SHALL be (rs_wbin - rptr_bin) modulo 2^(ASIZE+1), ASIZE+1 bits wide; this wrap-around arithmetic SHALL hold across pointer wrap.
REQ-019 rempty SHALL be combinational: 1 exactly when rs_wptr equals the Gray encoding of rptr_bin, i.e. raw level = 0; it SHALL never lag rptr_bin.
REQ-020 rlevel and ralmost_empty SHALL derive from the raw level (timing per REQ-027/028); ralmost_empty uses an unsigned compare.
REQ-021 lvl_err SHALL set on the rclk edge where raw level > 2^ASIZE, and SHALL remain set until clr_err is sampled high.
REQ-022 When clr_err and a new overflow condition occur on the same edge, set SHALL win and lvl_err SHALL stay 1.
REQ-023 Full level (raw level = 2^ASIZE, MSBs differ, rest equal) SHALL NOT set lvl_err.

Reset
REQ-024 Assertion of rrstn_n low SHALL immediately clear all synchroniser stages, lvl_err and any level register, without waiting for rclk.
REQ-025 During reset, rs_wptr=0, rs_wbin=0, lvl_err=0, rlevel=0 and ralmost_empty=1. rempty SHALL be 1 when rptr_bin=0.
REQ-026 On reset release mid-operation, outputs SHALL track the current wptr after STAGES rclk edges; no stale pre-reset value SHALL reappear.

Configuration
REQ-027 With macro SYNC_W2R_LVLREG_EN defined, rlevel and ralmost_empty SHALL be registered on rclk, adding one cycle latency relative to rs_wptr/rptr_bin; rempty SHALL stay combinational.
REQ-028 Without SYNC_W2R_LVLREG_EN, rlevel and ralmost_empty SHALL be combinational from rs_wptr and rptr_bin, zero added latency.

Verification
REQ-029 Reset: rrstn_n=0 with wptr=5'b01100 -> rs_wptr=0, rempty=1, ralmost_empty=1, lvl_err=0 immediately and with no rclk edge.
REQ-030 Latency: STAGES=3, rptr_bin=0, wptr steps 0->1 (Gray) -> rs_wptr=1 and rempty=0 exactly 3 rclk edges later; rlevel=1 on the same edge (one edge later with SYNC_W2R_LVLREG_EN).
REQ-031 Wrap: ASIZE=4, rptr_bin=5'd30, wptr=Gray(5'd2) -> after sync rlevel=4, rempty=0, ralmost_empty=0 (AE_THRESH=2).
REQ-032 Full/overflow: rptr_bin=0, wptr=Gray(16) -> rlevel=16, lvl_err=0; then wptr=Gray(17) -> lvl_err=1 and stays 1; clr_err pulse while rlevel=16 -> lvl_err=0.
REQ-033 Simultaneous: raw level=17 with clr_err=1 on the same edge -> lvl_err=1 after that edge.
REQ-034 Mid-run reset: 5 increments in flight, pulse rrstn_n low for 1 ns between rclk edges -> all outputs return to reset values at once, rs_wptr equals current wptr STAGES edges after release.

Source files
------------

// File: rtl/sync_w2r_level.sv
// ============================================================================
// Module   : sync_w2r_level
// Brief    : Write-to-read pointer synchroniser with read-domain fill level,
//            empty/almost-empty flags and a sticky level-overflow error.
//            Define SYNC_W2R_LVLREG_EN to register rlevel/ralmost_empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_w2r_level #(
    parameter int ASIZE     = 4,
    parameter int STAGES    = 2,
    parameter int AE_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrstn_n,
    input  logic [ASIZE:0]   wptr,
    input  logic [ASIZE:0]   rptr_bin,
    input  logic             clr_err,
    output logic [ASIZE:0]   rs_wptr,
    output logic [ASIZE:0]   rs_wbin,
    output logic [ASIZE:0]   rlevel,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic             lvl_err
);

    localparam logic [ASIZE:0] c_FULL = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] c_AE   = (ASIZE+1)'(AE_THRESH);

    logic [ASIZE:0] sync_d [STAGES];
    logic [ASIZE:0] sync_q [STAGES];
    logic           lvl_err_d;
    logic           lvl_err_q;

    logic [ASIZE:0] w_rptr_gray;
    logic [ASIZE:0] w_raw_level;
    logic           w_overflow;
    logic           w_ae;

    // Pure flop-to-flop chain: nothing may sit between wptr and the first stage.
    always_comb begin
        sync_d[0] = wptr;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge rclk or negedge rrstn_n) begin
        if (!rrstn_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign rs_wptr = sync_q[STAGES-1];

    always_comb begin
        rs_wbin = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            rs_wbin[i] = ^(rs_wptr >> i);
        end
    end

    assign w_rptr_gray = rptr_bin ^ (rptr_bin >> 1);
    assign w_raw_level = rs_wbin - rptr_bin;
    assign w_overflow  = (w_raw_level > c_FULL);
    assign w_ae        = (w_raw_level <= c_AE);

    // Empty compares Gray codes directly so it never lags the read pointer.
    assign rempty = (rs_wptr == w_rptr_gray);

    // A fresh overflow beats a simultaneous clear.
    always_comb begin
        lvl_err_d = lvl_err_q;
        if (w_overflow) begin
            lvl_err_d = 1'b1;
        end else if (clr_err) begin
            lvl_err_d = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rrstn_n) begin
        if (!rrstn_n) begin
            lvl_err_q <= 1'b0;
        end else begin
            lvl_err_q <= lvl_err_d;
        end
    end

    assign lvl_err = lvl_err_q;

`ifdef SYNC_W2R_LVLREG_EN
    logic [ASIZE:0] rlevel_d;
    logic [ASIZE:0] rlevel_q;
    logic           ralmost_empty_d;
    logic           ralmost_empty_q;

    always_comb begin
        rlevel_d        = w_raw_level;
        ralmost_empty_d = w_ae;
    end

    always_ff @(posedge rclk or negedge rrstn_n) begin
        if (!rrstn_n) begin
            rlevel_q        <= '0;
            ralmost_empty_q <= 1'b1;
        end else begin
            rlevel_q        <= rlevel_d;
            ralmost_empty_q <= ralmost_empty_d;
        end
    end

    assign rlevel        = rlevel_q;
    assign ralmost_empty = ralmost_empty_q;
`else
    assign rlevel        = w_raw_level;
    assign ralmost_empty = w_ae;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_w2r_level.sv
// ============================================================================
// Module   : tb_sync_w2r_level
// Brief    : Directed plus randomized bench for sync_w2r_level against a
//            pointer-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_sync_w2r_level;

    localparam int ASIZE  = 4;
    localparam int STAGES = 3;
    localparam int AE     = 2;
    localparam int W      = ASIZE + 1;
    localparam int MOD    = 1 << W;
    localparam int FULL   = 1 << ASIZE;
`ifdef SYNC_W2R_LVLREG_EN
    localparam int LVLREG = 1;
`else
    localparam int LVLREG = 0;
`endif

    logic         rclk = 1'b0;
    logic         rrstn_n = 1'b1;
    logic [W-1:0] wptr = '0;
    logic [W-1:0] rptr_bin = '0;
    logic         clr_err = 1'b0;
    logic [W-1:0] rs_wptr;
    logic [W-1:0] rs_wbin;
    logic [W-1:0] rlevel;
    logic         rempty;
    logic         ralmost_empty;
    logic         lvl_err;

    sync_w2r_level #(
        .ASIZE     (ASIZE),
        .STAGES    (STAGES),
        .AE_THRESH (AE)
    ) dut (
        .rclk          (rclk),
        .rrstn_n       (rrstn_n),
        .wptr          (wptr),
        .rptr_bin      (rptr_bin),
        .clr_err       (clr_err),
        .rs_wptr       (rs_wptr),
        .rs_wbin       (rs_wbin),
        .rlevel        (rlevel),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .lvl_err       (lvl_err)
    );

    always #5 rclk = ~rclk;

    // Reference model: the write count seen at each of the last STAGES edges.
    int hist [STAGES];
    int wbin;
    int rptr;
    int m_err;
    int m_lvl;
    int m_ae;
    int n_vec;
    int n_err;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int raw_now();
        return (hist[STAGES-1] - rptr) & (MOD - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        wbin     = wbin & (MOD - 1);
        rptr     = rptr & (MOD - 1);
        wptr     = W'(gray(wbin));
        rptr_bin = W'(rptr);
    endtask

    task automatic model_reset();
        for (int i = 0; i < STAGES; i++) hist[i] = 0;
        m_err = 0;
        m_lvl = 0;
        m_ae  = 1;
    endtask

    task automatic model_edge();
        int r;
        if (rrstn_n) begin
            r = raw_now();
            if (r > FULL) m_err = 1;
            else if (clr_err) m_err = 0;
            m_lvl = r;
            m_ae  = (r <= AE) ? 1 : 0;
            for (int i = STAGES - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = wbin;
        end
    endtask

    task automatic check_all();
        int r;
        r = raw_now();
        chk("rs_wptr", 32'(rs_wptr), 32'(gray(hist[STAGES-1])));
        chk("rs_wbin", 32'(rs_wbin), 32'(hist[STAGES-1]));
        chk("rempty", 32'(rempty), 32'((r == 0) ? 1 : 0));
        chk("rlevel", 32'(rlevel), 32'((LVLREG != 0) ? m_lvl : r));
        chk("ralmost_empty", 32'(ralmost_empty), 32'((LVLREG != 0) ? m_ae : ((r <= AE) ? 1 : 0)));
        chk("lvl_err", 32'(lvl_err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge rclk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        wbin  = 8;
        rptr  = 0;
        model_reset();
        drive();

        // Reset assertion with no clock edge, wptr = 5'b01100
        #0.5 rrstn_n = 1'b0;
        #0.5;
        chk("rst_wptr_in", 32'(wptr), 32'h0C);
        chk("rst_rs_wptr", 32'(rs_wptr), 32'h0);
        chk("rst_rempty", 32'(rempty), 32'h1);
        chk("rst_ae", 32'(ralmost_empty), 32'h1);
        chk("rst_lvl_err", 32'(lvl_err), 32'h0);
        chk("rst_rlevel", 32'(rlevel), 32'h0);
        #2 rrstn_n = 1'b1;

        wbin = 0;
        drive();
        repeat (STAGES + 2) tick();

        // Latency: 0 -> 1 appears after exactly STAGES edges
        wbin = 1;
        drive();
        tick();
        tick();
        chk("lat_e2_rs_wptr", 32'(rs_wptr), 32'h0);
        chk("lat_e2_rempty", 32'(rempty), 32'h1);
        tick();
        chk("lat_e3_rs_wptr", 32'(rs_wptr), 32'h1);
        chk("lat_e3_rempty", 32'(rempty), 32'h0);
        chk("lat_e3_rlevel", 32'(rlevel), 32'((LVLREG != 0) ? 0 : 1));
        tick();
        chk("lat_e4_rlevel", 32'(rlevel), 32'h1);

        // Pointer wrap: 2 - 30 mod 32 = 4
        rptr = 30;
        wbin = 2;
        drive();
        #1 check_all();
        repeat (STAGES + 2) tick();
        chk("wrap_rlevel", 32'(rlevel), 32'd4);
        chk("wrap_rempty", 32'(rempty), 32'h0);
        chk("wrap_ae", 32'(ralmost_empty), 32'h0);
        chk("wrap_err", 32'(lvl_err), 32'h0);

        // Full is not an error; one beyond is, and it is sticky
        rptr = 0;
        wbin = 16;
        drive();
        repeat (STAGES + 2) tick();
        chk("full_rlevel", 32'(rlevel), 32'd16);
        chk("full_err", 32'(lvl_err), 32'h0);
        wbin = 17;
        drive();
        repeat (STAGES + 2) tick();
        chk("ovf_err", 32'(lvl_err), 32'h1);
        wbin = 16;
        drive();
        repeat (STAGES + 2) tick();
        chk("ovf_sticky", 32'(lvl_err), 32'h1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_at_full", 32'(lvl_err), 32'h0);
        chk("clr_rlevel", 32'(rlevel), 32'd16);

        // Overflow and clear on the same edge: set wins
        clr_err = 1'b1;
        wbin = 17;
        drive();
        repeat (STAGES + 2) tick();
        chk("set_wins", 32'(lvl_err), 32'h1);
        clr_err = 1'b0;
        rptr = 17;
        drive();
        #1 check_all();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // Randomized traffic, occasional jumps that overflow
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) wbin = wbin + $urandom_range(2, 20);
            else wbin = wbin + $urandom_range(0, 1);
            if (((wbin - rptr) & (MOD - 1)) != 0 && $urandom_range(0, 2) != 0) rptr = rptr + 1;
            clr_err = ($urandom_range(0, 15) == 0);
            drive();
            #1 check_all();
            tick();
        end
        clr_err = 1'b0;

        // Mid-run reset with increments still in flight
        repeat (5) begin
            wbin = wbin + 1;
            drive();
            tick();
        end
        #2;
        rrstn_n = 1'b0;
        rptr = 0;
        drive();
        model_reset();
        #0.5;
        check_all();
        chk("mid_rst_rs_wptr", 32'(rs_wptr), 32'h0);
        chk("mid_rst_rlevel", 32'(rlevel), 32'h0);
        chk("mid_rst_ae", 32'(ralmost_empty), 32'h1);
        chk("mid_rst_err", 32'(lvl_err), 32'h0);
        #0.5 rrstn_n = 1'b1;
        repeat (STAGES) tick();
        chk("mid_rel_track", 32'(rs_wptr), 32'(gray(wbin)));
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
